// File: rtl/rv32i_types.sv
// rv32i_types: shared load/store sequencer states, trap causes and funct3 encodings
package rv32i_types;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, TRAP} lsu_state_t;
  typedef enum logic [1:0] {MISALIGNED = 2'd0, ILLEGAL = 2'd1, TIMEOUT = 2'd2} lsu_cause_t;
  typedef enum logic [2:0] {
    lb = 3'b000, lh = 3'b001, lw = 3'b010, ld = 3'b011,
    lbu = 3'b100, lhu = 3'b101, lwu = 3'b110
  } load_funct3_t;
  typedef enum logic [2:0] {sb = 3'b000, sh = 3'b001, sw = 3'b010, sd = 3'b011} store_funct3_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane alignment, load extension and legality decode for one access
// ports: funct3/write/offset describe the access; wdata/rdata are the raw store and
// memory read data; byte_enable, shifted_wdata and rdata_ext are the lane-aligned
// results; misaligned and illegal flag accesses that must trap
module lsu_align import rv32i_types::*; #(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic            write,
  input  logic [OB-1:0]   offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   byte_enable,
  output logic [XLEN-1:0] shifted_wdata,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned,
  output logic            illegal
);
  logic [1:0] size;
  logic [NB-1:0] smask;
  logic [XLEN-1:0] rsh;
  logic sgn, fill;
  always_comb begin
    size = funct3[1:0];
    smask = size == 2'd0 ? NB'(1) : size == 2'd1 ? NB'(3) : size == 2'd2 ? NB'(15) : '1;
    rsh = rdata >> {offset, 3'b000};
    sgn = size == 2'd0 ? rsh[7] : size == 2'd1 ? rsh[15] : rsh[31];
    fill = sgn & ~funct3[2];
    byte_enable = smask << offset;
    shifted_wdata = wdata << {offset, 3'b000};
    illegal = write ? !(funct3 inside {sb, sh, sw} || (XLEN == 64 && funct3 == sd))
                    : !(funct3 inside {lb, lh, lw, lbu, lhu} || (XLEN == 64 && funct3 inside {ld, lwu}));
    misaligned = size == 2'd1 ? offset[0] : size == 2'd2 ? |offset[1:0] : size == 2'd3 ? |offset : 1'b0;
  end
  // lanes outside the access size take the sign/zero fill
  genvar i;
  for (i = 0; i < NB; i++) begin : g_lane
    assign rdata_ext[8*i +: 8] = smask[i] ? rsh[8*i +: 8] : {8{fill}};
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core control FSM and the memory port
// ports: req_* is the access request (accepted while req_ready); mem_* is the memory
// port with strobe held until mem_resp; done/rdata/rmask/wmask report completion;
// trap/trap_cause report misaligned, illegal or timed-out accesses; rst is active-low async
module lsu_ctrl import rv32i_types::*; #(
  parameter int XLEN = 32,
  parameter int MAX_WAIT = 0,
  localparam int NB = XLEN / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] mem_address,
  output logic            mem_read,
  output logic            mem_write,
  output logic [NB-1:0]   mem_byte_enable,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   rmask,
  output logic [NB-1:0]   wmask,
  output logic            trap,
  output logic [1:0]      trap_cause
);
  localparam int CW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_WAIT == 0 ? 0 : MAX_WAIT - 1);
  lsu_state_t state, next;
  lsu_cause_t cause_q;
  logic [2:0] f3_q, f3;
  logic [OB-1:0] off_q, off;
  logic write_q, wr, idle, tmo, mis, ill;
  logic [CW-1:0] cnt;
  logic [NB-1:0] be;
  logic [XLEN-1:0] wd_sh, rd_ext;
  // the aligner sees the live request while idle and the captured access afterwards
  assign idle = state == IDLE;
  assign f3 = idle ? req_funct3 : f3_q;
  assign off = idle ? req_addr[OB-1:0] : off_q;
  assign wr = idle ? req_write : write_q;
  assign tmo = MAX_WAIT != 0 && !mem_resp && cnt == LIM;
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3(f3), .write(wr), .offset(off), .wdata(req_wdata), .rdata(mem_rdata),
    .byte_enable(be), .shifted_wdata(wd_sh), .rdata_ext(rd_ext),
    .misaligned(mis), .illegal(ill)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = idle ? (req_valid ? (ill | mis ? TRAP : ACCESS) : IDLE)
         : state == ACCESS ? (mem_resp ? DONE : tmo ? TRAP : ACCESS) : IDLE;
  end
  always_comb begin
    req_ready = idle;
    done = state == DONE;
    trap = state == TRAP;
    trap_cause = trap ? cause_q : 2'd0;
    rmask = done && !write_q ? mem_byte_enable : '0;
    wmask = done && write_q ? mem_byte_enable : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_address <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_byte_enable <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      f3_q <= '0;
      off_q <= '0;
      write_q <= 1'b0;
      cause_q <= MISALIGNED;
      cnt <= '0;
    end else if (idle && req_valid) begin
      mem_address <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
      mem_byte_enable <= be;
      mem_wdata <= wd_sh;
      mem_read <= !(ill | mis) && !req_write;
      mem_write <= !(ill | mis) && req_write;
      f3_q <= req_funct3;
      off_q <= req_addr[OB-1:0];
      write_q <= req_write;
      cause_q <= ill ? ILLEGAL : MISALIGNED;
      cnt <= '0;
    end else if (state == ACCESS) begin
      if (mem_resp || tmo) begin
        mem_read <= 1'b0;
        mem_write <= 1'b0;
      end
      if (mem_resp && !write_q) rdata <= rd_ext;
      if (!mem_resp && tmo) cause_q <= TIMEOUT;
      if (!mem_resp && !tmo) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl at XLEN 32 (MAX_WAIT 4) and XLEN 64
module tb_lsu_ctrl;
  logic clk = 1'b0, rst = 1'b0, sel = 1'b0;
  logic v32 = 1'b0, v64 = 1'b0, resp32 = 1'b0, resp64 = 1'b0;
  logic req_write = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic r32, rd32, wr32, d32, t32, r64, rd64, wr64, d64, t64;
  logic [31:0] ma32, wd32, rdat32;
  logic [63:0] ma64, wd64, rdat64;
  logic [3:0] be32, rm32, wm32;
  logic [7:0] be64, rm64, wm64;
  logic [1:0] c32, c64;
  logic m_ready, m_rd, m_wr, m_done, m_trap;
  logic [1:0] m_cause;
  logic [7:0] m_be, m_rmask, m_wmask;
  logic [63:0] m_addr, m_wd, m_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lsu_ctrl #(.XLEN(32), .MAX_WAIT(4)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(r32), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .mem_address(ma32), .mem_read(rd32), .mem_write(wr32), .mem_byte_enable(be32),
    .mem_wdata(wd32), .mem_rdata(mem_rdata[31:0]), .mem_resp(resp32), .done(d32),
    .rdata(rdat32), .rmask(rm32), .wmask(wm32), .trap(t32), .trap_cause(c32)
  );
  lsu_ctrl #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(r64), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_address(ma64), .mem_read(rd64), .mem_write(wr64), .mem_byte_enable(be64),
    .mem_wdata(wd64), .mem_rdata(mem_rdata), .mem_resp(resp64), .done(d64),
    .rdata(rdat64), .rmask(rm64), .wmask(wm64), .trap(t64), .trap_cause(c64)
  );
  always_comb begin
    m_ready = sel ? r64 : r32;
    m_rd = sel ? rd64 : rd32;
    m_wr = sel ? wr64 : wr32;
    m_done = sel ? d64 : d32;
    m_trap = sel ? t64 : t32;
    m_cause = sel ? c64 : c32;
    m_be = sel ? be64 : {4'b0, be32};
    m_rmask = sel ? rm64 : {4'b0, rm32};
    m_wmask = sel ? wm64 : {4'b0, wm32};
    m_addr = sel ? ma64 : {32'b0, ma32};
    m_wd = sel ? wd64 : {32'b0, wd32};
    m_rdata = sel ? rdat64 : {32'b0, rdat32};
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    req_write = w; req_funct3 = f; req_addr = a; req_wdata = wd;
    if (sel) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    req_addr = '1; req_funct3 = 3'd7; req_wdata = '0; req_write = ~w;
  endtask
  task automatic acc(input string tag, input logic w, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] mrd, input logic [7:0] ebe,
                     input logic [63:0] ewd, input logic [63:0] erd);
    issue(w, f, a, wd);
    chk({tag, " strobe"}, w ? m_wr : m_rd, 1'b1);
    chk({tag, " ready"}, m_ready, 1'b0);
    chk({tag, " addr"}, m_addr, a & ~(sel ? 64'h7 : 64'h3));
    chk({tag, " be"}, m_be, ebe);
    if (w) chk({tag, " wdata"}, m_wd, ewd);
    mem_rdata = mrd;
    if (sel) resp64 = 1'b1; else resp32 = 1'b1;
    @(negedge clk);
    resp32 = 1'b0; resp64 = 1'b0;
    chk({tag, " done"}, m_done, 1'b1);
    chk({tag, " strobes off"}, {m_rd, m_wr}, 2'b00);
    chk({tag, " rdata"}, m_rdata, erd);
    chk({tag, " mask"}, w ? m_wmask : m_rmask, ebe);
    chk({tag, " other mask"}, w ? m_rmask : m_wmask, 8'h00);
    @(negedge clk);
    chk({tag, " ready after"}, m_ready, 1'b1);
    chk({tag, " done pulse"}, m_done, 1'b0);
  endtask
  task automatic trp(input string tag, input logic w, input logic [2:0] f, input logic [63:0] a,
                     input logic [1:0] ecause);
    issue(w, f, a, 64'h0);
    chk({tag, " trap"}, m_trap, 1'b1);
    chk({tag, " cause"}, m_cause, ecause);
    chk({tag, " no strobe"}, {m_rd, m_wr}, 2'b00);
    chk({tag, " done"}, m_done, 1'b0);
    @(negedge clk);
    chk({tag, " trap pulse"}, m_trap, 1'b0);
    chk({tag, " no strobe 2"}, {m_rd, m_wr}, 2'b00);
    chk({tag, " ready"}, m_ready, 1'b1);
  endtask
  initial begin
    int n;
    logic seen;
    logic [1:0] c;
    @(negedge clk);
    chk("reset ready32", r32, 1'b1);
    chk("reset ready64", r64, 1'b1);
    chk("reset strobes", {rd32, wr32, rd64, wr64}, 4'b0);
    chk("reset outputs", {d32, t32, c32, rm32, wm32, be32}, '0);
    chk("reset rdata", {rdat32, rdat64}, '0);
    chk("reset addr", ma32, 32'h0);
    rst = 1'b1;
    acc("lb", 0, 3'b000, 64'h1003, 0, 64'h80FF_0000, 8'h08, 0, 64'hFFFF_FF80);
    acc("sh", 1, 3'b001, 64'h2002, 64'hABCD, 0, 8'h0C, 64'hABCD_0000, 64'hFFFF_FF80);
    acc("lhu", 0, 3'b101, 64'h6002, 0, 64'h8001_0000, 8'h0C, 0, 64'h0000_8001);
    acc("lh", 0, 3'b001, 64'h6002, 0, 64'h8001_0000, 8'h0C, 0, 64'hFFFF_8001);
    acc("lbu", 0, 3'b100, 64'h6001, 0, 64'h0000_A500, 8'h02, 0, 64'h0000_00A5);
    acc("sb", 1, 3'b000, 64'h7001, 64'h1234_5678, 0, 8'h02, 64'h3456_7800, 64'h0000_00A5);
    acc("sw", 1, 3'b010, 64'h7004, 64'hDEAD_BEEF, 0, 8'h0F, 64'hDEAD_BEEF, 64'h0000_00A5);
    trp("lw mis", 0, 3'b010, 64'h3001, 2'd0);
    trp("ld x32", 0, 3'b011, 64'h4000, 2'd1);
    trp("lwu x32", 0, 3'b110, 64'h4000, 2'd1);
    trp("st f3 100", 1, 3'b100, 64'h4000, 2'd1);
    trp("sd mis x32", 1, 3'b011, 64'h4001, 2'd1);
    trp("sh mis", 1, 3'b001, 64'h4003, 2'd0);
    issue(0, 3'b010, 64'h5000, 0);
    n = 0; seen = 1'b0; c = 2'd3;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (m_rd) n++;
      if (m_trap) begin seen = 1'b1; c = m_cause; end
      if (!seen) @(negedge clk);
    end
    chk("timeout strobe cycles", n, 4);
    chk("timeout trap", seen, 1'b1);
    chk("timeout cause", c, 2'd2);
    @(negedge clk);
    chk("timeout ready", m_ready, 1'b1);
    issue(0, 3'b010, 64'h5000, 0);
    mem_rdata = 64'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      chk("limit strobe", m_rd, 1'b1);
      @(negedge clk);
    end
    chk("limit strobe 4", m_rd, 1'b1);
    resp32 = 1'b1;
    @(negedge clk);
    resp32 = 1'b0;
    chk("limit done", m_done, 1'b1);
    chk("limit no trap", m_trap, 1'b0);
    chk("limit rdata", m_rdata, 64'h1234_5678);
    @(negedge clk);
    issue(0, 3'b010, 64'h5000, 0);
    chk("rst pre strobe", m_rd, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst strobe async", m_rd, 1'b0);
    chk("rst ready async", m_ready, 1'b1);
    chk("rst rdata", m_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    resp32 = 1'b1;
    @(negedge clk);
    resp32 = 1'b0;
    chk("rst no done", m_done, 1'b0);
    chk("rst no trap", m_trap, 1'b0);
    chk("rst still idle", {m_ready, m_rd}, 2'b10);
    sel = 1'b1;
    acc("ld", 0, 3'b011, 64'h8, 0, 64'h8877_6655_4433_2211, 8'hFF, 0, 64'h8877_6655_4433_2211);
    acc("lwu", 0, 3'b110, 64'hC, 0, 64'h8000_0001_0000_0000, 8'hF0, 0, 64'h0000_0000_8000_0001);
    acc("lw64", 0, 3'b010, 64'hC, 0, 64'h8000_0001_0000_0000, 8'hF0, 0, 64'hFFFF_FFFF_8000_0001);
    acc("sd", 1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 0, 8'hFF, 64'h1122_3344_5566_7788,
        64'hFFFF_FFFF_8000_0001);
    trp("ld mis", 0, 3'b011, 64'h14, 2'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
